// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes agreed with the control unit,
// default widths and the execute-stage FSM state type.
package alu_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int SHAMT_W_DEF = 5;

  localparam logic [3:0] ALU_NOP   = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0001;
  localparam logic [3:0] ALU_ADDI  = 4'b0010;
  localparam logic [3:0] ALU_SLL   = 4'b0011;
  localparam logic [3:0] ALU_SLT   = 4'b0100;
  localparam logic [3:0] ALU_SLTU  = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1000;
  localparam logic [3:0] ALU_OR    = 4'b1001;
  localparam logic [3:0] ALU_AND   = 4'b1010;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_exec_stage_serial_shifter.sv
// One-bit-per-cycle shifter used for shifts of two or more positions.
// The first bit is applied at load, so the counter starts at amount-1.
module serial_shifter
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [XLEN-1:0]    value,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               direction,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    shifted
);

  localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);

  logic [XLEN-1:0]    work;
  logic [SHAMT_W-1:0] count;
  logic               dir_right;

  // shifted is the next work value; on the done cycle it is the final result
  assign shifted = dir_right ? (work >> 1) : (work << 1);
  assign busy    = (count != '0);
  assign done    = (count == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      count     <= '0;
      dir_right <= 1'b0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      work      <= direction ? (value >> 1) : (value << 1);
      count     <= amount - ONE;
      dir_right <= direction;
    end else if (busy) begin
      work  <= shifted;
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU plus a serial shifter, with a valid/ready
// input and a result register that holds until writeback accepts it.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ctrl_sig,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  state_t             state, state_nx;
  logic [SHAMT_W-1:0] shamt;
  logic               accept, shift_long, wr_fast, wr_shift;
  logic [XLEN-1:0]    alu_res, sh_value;
  logic               alu_ill, sh_busy, sh_done;

  assign shamt      = op_b[SHAMT_W-1:0];
  assign shift_long = is_shift(ctrl_sig) && (shamt[SHAMT_W-1:1] != '0);
  assign in_ready   = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept     = in_valid && in_ready;
  assign wr_fast    = accept && !shift_long;
  assign wr_shift   = (state == SHIFT) && sh_done && !flush;

  // Shifts by 0 or 1 are cheap enough to finish here without the serial path
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ctrl_sig)
      ALU_NOP:           alu_res = '0;
      ALU_ADD, ALU_ADDI: alu_res = op_a + op_b;
      ALU_SLL:           alu_res = shamt[0] ? (op_a << 1) : op_a;
      ALU_SLT:           alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:          alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:           alu_res = op_a ^ op_b;
      ALU_SRL:           alu_res = shamt[0] ? (op_a >> 1) : op_a;
      ALU_PASSB:         alu_res = op_b;
      ALU_OR:            alu_res = op_a | op_b;
      ALU_AND:           alu_res = op_a & op_b;
      default:           alu_ill = 1'b1;
    endcase
  end

  serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .load      (accept && shift_long),
    .value     (op_a),
    .amount    (shamt),
    .direction (ctrl_sig == ALU_SRL),
    .busy      (sh_busy),
    .done      (sh_done),
    .shifted   (sh_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // An idle shifter while in SHIFT can only mean a lost operation, so fall back to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && shift_long) state_nx = SHIFT;
      SHIFT:   if (sh_done || !sh_busy)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (wr_fast) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      illegal   <= alu_ill;
    end else if (wr_shift) begin
      out_valid <= 1'b1;
      result    <= sh_value;
      illegal   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, handshake and
// flush/reset sequences, then random traffic against a behavioural model.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [3:0]  ctrl_sig;
  logic [31:0] op_a, op_b, result;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int NRAND = 150;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl_sig  (ctrl_sig),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_ill;
    int          exp_lat;
  } vec_t;

  vec_t vecs[20];

  // Reference: {illegal, result} straight from the opcode table
  function automatic logic [32:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int          sh;
    logic [31:0] r;
    logic        ill;
    sh  = int'(b % 32);
    r   = 32'd0;
    ill = 1'b0;
    case (c)
      4'd0:       r = 32'd0;
      4'd1, 4'd2: r = a + b;
      4'd3:       r = a << sh;
      4'd4:       r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:       r = (a < b) ? 32'd1 : 32'd0;
      4'd6:       r = a ^ b;
      4'd7:       r = a >> sh;
      4'd8:       r = b;
      4'd9:       r = a | b;
      4'd10:      r = a & b;
      default:    ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle the result shows up
  task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output int low_cnt,
                               output logic [31:0] res, output logic ill);
    int guard;
    ctrl_sig = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 64) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL accept timeout: in_ready stuck at 0, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 1;
    low_cnt  = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) low_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    ill = illegal;
  endtask

  initial begin
    int          lat, low, seen, guard, cyc, issued;
    logic [31:0] res;
    logic        ill, acc_last;
    logic [31:0] xa[4], xb[4], xe[4];
    logic [32:0] exp_q[$];
    logic [32:0] exp_item;

    vecs[0]  = '{4'h1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
    vecs[1]  = '{4'h4, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
    vecs[2]  = '{4'h5, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
    vecs[3]  = '{4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1};
    vecs[4]  = '{4'h3, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 31};
    vecs[5]  = '{4'h7, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1};
    vecs[6]  = '{4'h7, 32'h8000_0000, 32'h0000_0001, 32'h4000_0000, 1'b0, 1};
    vecs[7]  = '{4'h7, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 1'b0, 4};
    vecs[8]  = '{4'h3, 32'h0000_00FF, 32'h0000_0002, 32'h0000_03FC, 1'b0, 2};
    vecs[9]  = '{4'h3, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0, 1};
    vecs[10] = '{4'h6, 32'h0F0F_0F0F, 32'hFF00_FF00, 32'hF00F_F00F, 1'b0, 1};
    vecs[11] = '{4'h9, 32'h1200_0034, 32'h0000_5600, 32'h1200_5634, 1'b0, 1};
    vecs[12] = '{4'hA, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 1'b0, 1};
    vecs[13] = '{4'h8, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1};
    vecs[14] = '{4'h0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b0, 1};
    vecs[15] = '{4'h2, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0006, 1'b0, 1};
    vecs[16] = '{4'hF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};
    vecs[17] = '{4'h4, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000, 1'b0, 1};
    vecs[18] = '{4'h5, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1};
    vecs[19] = '{4'h3, 32'h0000_0003, 32'h0000_0001, 32'h0000_0006, 1'b0, 1};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ctrl_sig  = 4'h0;
    op_a      = 32'd0;
    op_b      = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset illegal", {31'd0, illegal}, 32'd0);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].b, lat, low, res, ill);
      checkOutput($sformatf("vec%0d result", i), res, vecs[i].exp_res);
      checkOutput($sformatf("vec%0d illegal", i), {31'd0, ill}, {31'd0, vecs[i].exp_ill});
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("vec%0d in_ready low cycles", i), 32'(low), 32'(vecs[i].exp_lat - 1));
    end

    // Four XORs with writeback stalled for three cycles after the first result
    for (int i = 0; i < 4; i++) begin
      xa[i] = $urandom;
      xb[i] = $urandom;
      exp_item = ref_alu(4'h6, xa[i], xb[i]);
      xe[i] = exp_item[31:0];
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    ctrl_sig  = 4'h6;
    op_a      = xa[0];
    op_b      = xb[0];
    in_valid  = 1'b1;
    #1;
    checkOutput("xor first in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    op_a = xa[1];
    op_b = xb[1];
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("xor stall%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("xor stall%0d result", k), result, xe[0]);
      checkOutput($sformatf("xor stall%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checkOutput("xor release in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("xor%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("xor%0d result", i), result, xe[i]);
      if (i < 3) begin
        op_a = xa[i+1];
        op_b = xb[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    checkOutput("xor drained out_valid", {31'd0, out_valid}, 32'd0);

    // Flush in the third cycle of a 10-bit shift, with an ADD offered alongside
    ctrl_sig = 4'h3;
    op_a     = 32'd1;
    op_b     = 32'd10;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush    = 1'b1;
    ctrl_sig = 4'h1;
    op_a     = 32'd2;
    op_b     = 32'd3;
    in_valid = 1'b1;
    #1;
    checkOutput("flush in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("flush out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush back to idle", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("flush no late result", 32'(seen), 32'd0);
    applyStimulus(4'h1, 32'd5, 32'd6, lat, low, res, ill);
    checkOutput("post-flush add result", res, 32'd11);
    checkOutput("post-flush add latency", 32'(lat), 32'd1);

    // Asynchronous reset in the middle of a shift
    @(posedge clk); #1;
    ctrl_sig = 4'h3;
    op_a     = 32'd1;
    op_b     = 32'd20;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset result", result, 32'd0);
    checkOutput("async reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async reset illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("after reset in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("abandoned shift silent", 32'(seen), 32'd0);

    // Random traffic with random writeback stalls, checked in order
    issued   = 0;
    cyc      = 0;
    acc_last = 1'b0;
    in_valid = 1'b0;
    while ((issued < NRAND || exp_q.size() != 0) && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (acc_last) in_valid = 1'b0;
      if (!in_valid && issued < NRAND && $urandom_range(0, 2) != 0) begin
        ctrl_sig = 4'($urandom_range(0, 15));
        op_a     = $urandom;
        op_b     = $urandom;
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc_last = in_valid && in_ready;
      if (acc_last) begin
        exp_q.push_back(ref_alu(ctrl_sig, op_a, op_b));
        issued++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL random extra result: got 0x%08h, required none", result);
        end else begin
          exp_item = exp_q.pop_front();
          checkOutput("random result", result, exp_item[31:0]);
          checkOutput("random illegal", {31'd0, illegal}, {31'd0, exp_item[32]});
        end
      end
    end
    in_valid = 1'b0;
    checkOutput("random issued", 32'(issued), 32'(NRAND));
    checkOutput("random drained", 32'(exp_q.size()), 32'd0);

    guard = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
